instr_encode_writer: RTL and testbench
======================================

Name: instr_encode_writer

Overview:
- Inverse of the instruction decode stage. Accepts instruction fields (class, opcode, registers, condition, immediate) over a valid/ready stream and packs each into the 32-bit class ISA word.
- Buffers encoded words in a small FIFO and writes them to instruction memory at consecutive word addresses from a programmable base.
- Used as the program loader / self-test stimulus writer feeding the fetch path.

Parameters:
AW, 10, instruction memory word-address width
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
start  in  1  one-cycle pulse; latches base_addr and enters RUN (honoured only in IDLE)
base_addr  in  AW  first write address
finish  in  1  pulse; stop accepting and drain (honoured only in RUN)
in_valid  in  1  field bundle valid
in_ready  out  1  bundle accepted when in_valid & in_ready
in_class  in  2  instruction bits 31:30
in_opcode  in  5  bits 29:25 (class 10: only bit0 used, 1 = store; class 11: bit4 must be 0)
in_rd  in  3  field placed at 24:22
in_rs1  in  3  field placed at 21:19
in_rs2  in  3  field placed at 18:16
in_cond  in  4  branch condition, bits 24:21
in_imm  in  16  bits 15:0
imem_we  out  1  write request
imem_ready  in  1  memory accepts the write this cycle
imem_addr  out  AW  write word address
imem_wdata  out  32  encoded word
done  out  1  one-cycle pulse after drain completes
busy  out  1  state != IDLE
err  out  1  sticky illegal-encoding flag, cleared by start
words_written  out  16  writes completed since start, saturating

Behaviour:
- Reset (async): state IDLE, FIFO empty, imem_we=0, imem_addr=0, in_ready=0, done=0, busy=0, err=0, words_written=0. Asserting reset mid-operation discards FIFO contents and drops imem_we immediately.
- States: IDLE -start-> RUN; RUN -finish-> DRAIN; DRAIN -(FIFO empty and no write pending)-> DONE; DONE -> IDLE (done=1 for exactly this cycle).
- start outside IDLE and finish outside RUN are ignored.
- in_ready = (state==RUN) & FIFO not full. It does not depend on a same-cycle pop.
- Encoding is combinational on the inputs and pushed on the accept edge. Fields not used by the instruction are forced to 0.
  - Class 00:
    - mov/movt (00000, 00001): rd, imm.
    - add, adds, sub, subs, and, ands, or, ors, xor, xors (10001, 11001, 10010, 11010, 10011, 11011, 10100, 11100, 10101, 11101), lsl (00100), lsr (00101), clr (00010), set (00011): rd, rs1, imm.
  - Class 01:
    - Same ten ALU opcodes: rd, rs1, rs2.
    - NOT (10110): rd, rs1.
  - Class 10: bits 29:26=0, bit25=opcode[0]; rd, rs1, imm.
  - Class 11, opcode[3:0]:
    - 0000: imm.
    - 0001: cond, imm.
    - 0010: rs1, imm.
    - 0100 (NOP) and 1000 (HALT): bits 24:0 zero.
  - Any other class/opcode combination is illegal: it is accepted (handshake completes) but not pushed; err is set.
- Memory side:
  - imem_we = FIFO not empty & state in {RUN, DRAIN}.
  - imem_wdata = FIFO head; imem_addr = current address.
  - On imem_we & imem_ready: pop, address +1 (wraps modulo 2^AW), words_written +1 (saturates at 0xFFFF).
  - imem_we held with stable addr/data until imem_ready.
- Latency: a word accepted at edge N is presented on imem_we from cycle N+1. Simultaneous push and pop leave the count unchanged. Throughput is 1 word/cycle with imem_ready held high.
- finish in the same cycle as an accept: the accepted word is still pushed and written.

Test Plan:
- Base 0x010; add r3,r1,#5 (class 00, op 10001, rd3, rs1 1, imm 0x0005) -> imem_wdata=0x22C80005 at addr 0x010 one cycle after accept.
- Bcond cond 1010 imm 0x0010 (class 11, op 00001), then store rd2, rs1 5, imm 4 (class 10, op 00001) -> 0xC3400010 @base, 0x82A80004 @base+1.
- NOP, HALT, and class 01 op 00000 -> 0xC8000000, 0xD0000000 written; illegal dropped, err=1, words_written=2.
- imem_ready low 6 cycles while pushing 5 words, DEPTH 4 -> in_ready drops after 4, imem_addr/data stable, all 5 words written in order.
- base 0x3FF, two words -> addresses 0x3FF then 0x000; then finish -> done pulses once after the last write, busy falls.
- Reset asserted with 3 words queued -> imem_we low asynchronously, FIFO empty; a following start at base 0 writes the first new word at 0.

Source files
------------

// File: rtl/instr_encode_writer.sv
// Packs instruction field bundles into 32-bit class ISA words and streams them
// through a small FIFO into instruction memory at consecutive word addresses.
module instr_encode_writer #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_class,
    input  logic [4:0]    in_opcode,
    input  logic [2:0]    in_rd,
    input  logic [2:0]    in_rs1,
    input  logic [2:0]    in_rs2,
    input  logic [3:0]    in_cond,
    input  logic [15:0]   in_imm,
    output logic          imem_we,
    input  logic          imem_ready,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic [15:0]   words_written
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_fifo [DEPTH];
    logic [PW:0]   r_wptr;
    logic [PW:0]   r_rptr;
    logic [AW-1:0] r_addr;
    logic          r_err;
    logic [CW-1:0] r_words;

    logic          w_empty;
    logic          w_full;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_start_ok;
    logic          w_alu;
    logic          w_legal;
    logic          w_use_rd;
    logic          w_use_rs1;
    logic          w_use_rs2;
    logic          w_use_cond;
    logic          w_use_imm;
    logic [4:0]    w_op_field;
    logic [31:0]   w_word;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign in_ready   = (r_state == S_RUN) && !w_full;
    assign imem_we    = !w_empty && ((r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_accept   = in_valid && in_ready;
    assign w_push     = w_accept && w_legal;
    assign w_pop      = imem_we && imem_ready;
    assign w_start_ok = start && (r_state == S_IDLE);
    assign w_alu      = in_opcode inside {5'b10001, 5'b11001, 5'b10010, 5'b11010, 5'b10011,
                                          5'b11011, 5'b10100, 5'b11100, 5'b10101, 5'b11101};

    // Field-usage decode per class/opcode; unused fields stay zero in the word
    always_comb begin
        w_legal    = 1'b0;
        w_use_rd   = 1'b0;
        w_use_rs1  = 1'b0;
        w_use_rs2  = 1'b0;
        w_use_cond = 1'b0;
        w_use_imm  = 1'b0;
        w_op_field = in_opcode;
        case (in_class)
            2'b00: begin
                if (in_opcode inside {5'b00000, 5'b00001}) begin
                    w_legal   = 1'b1;
                    w_use_rd  = 1'b1;
                    w_use_imm = 1'b1;
                end else if (w_alu || (in_opcode inside {5'b00010, 5'b00011, 5'b00100, 5'b00101})) begin
                    w_legal   = 1'b1;
                    w_use_rd  = 1'b1;
                    w_use_rs1 = 1'b1;
                    w_use_imm = 1'b1;
                end
            end
            2'b01: begin
                if (w_alu) begin
                    w_legal   = 1'b1;
                    w_use_rd  = 1'b1;
                    w_use_rs1 = 1'b1;
                    w_use_rs2 = 1'b1;
                end else if (in_opcode == 5'b10110) begin
                    w_legal   = 1'b1;
                    w_use_rd  = 1'b1;
                    w_use_rs1 = 1'b1;
                end
            end
            2'b10: begin
                w_legal    = 1'b1;
                w_use_rd   = 1'b1;
                w_use_rs1  = 1'b1;
                w_use_imm  = 1'b1;
                w_op_field = {4'b0000, in_opcode[0]};
            end
            default: begin
                if (!in_opcode[4]) begin
                    case (in_opcode[3:0])
                        4'b0000: begin
                            w_legal   = 1'b1;
                            w_use_imm = 1'b1;
                        end
                        4'b0001: begin
                            w_legal    = 1'b1;
                            w_use_cond = 1'b1;
                            w_use_imm  = 1'b1;
                        end
                        4'b0010: begin
                            w_legal   = 1'b1;
                            w_use_rs1 = 1'b1;
                            w_use_imm = 1'b1;
                        end
                        4'b0100, 4'b1000: w_legal = 1'b1;
                        default: w_legal = 1'b0;
                    endcase
                end
            end
        endcase

        w_word = {in_class, w_op_field, 25'd0};
        if (w_use_rd)   w_word[24:22] = in_rd;
        if (w_use_cond) w_word[24:21] = in_cond;
        if (w_use_rs1)  w_word[21:19] = in_rs1;
        if (w_use_rs2)  w_word[18:16] = in_rs2;
        if (w_use_imm)  w_word[15:0]  = in_imm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)   w_next = S_RUN;
            S_RUN:   if (finish)  w_next = S_DRAIN;
            S_DRAIN: if (w_empty) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pointers, write address, counters and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
            r_words <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
            if (w_start_ok) begin
                r_addr  <= base_addr;
                r_err   <= 1'b0;
                r_words <= '0;
            end else begin
                if (w_pop) begin
                    r_addr <= r_addr + AW'(1);
                    if (r_words != {CW{1'b1}}) r_words <= r_words + CW'(1);
                end
                if (w_accept && !w_legal) r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr[PW-1:0]] <= w_word;
    end

    assign imem_addr     = r_addr;
    assign imem_wdata    = r_fifo[r_rptr[PW-1:0]];
    assign done          = (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE);
    assign err           = r_err;
    assign words_written = r_words;

endmodule

// File: tb/tb_instr_encode_writer.sv
// Directed and randomized checks of instr_encode_writer against a field-rule
// encoding model and a memory-write log.
module tb_instr_encode_writer;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          finish = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_class = '0;
    logic [4:0]    in_opcode = '0;
    logic [2:0]    in_rd = '0;
    logic [2:0]    in_rs1 = '0;
    logic [2:0]    in_rs2 = '0;
    logic [3:0]    in_cond = '0;
    logic [15:0]   in_imm = '0;
    logic          imem_we;
    logic          imem_ready = 1'b1;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          done;
    logic          busy;
    logic          err;
    logic [15:0]   words_written;

    instr_encode_writer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_cond(in_cond), .in_imm(in_imm),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .done(done), .busy(busy), .err(err),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            rdy_mode = 0;    // 0: ready high, 1: ready low, 2: random
    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];
    logic [31:0]   exp_data[$];
    logic [AW-1:0] exp_base;
    bit            exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Encoding straight from the class/opcode field rules
    function automatic bit model_enc(input logic [1:0] c, input logic [4:0] op,
                                     input logic [2:0] rd, input logic [2:0] rs1,
                                     input logic [2:0] rs2, input logic [3:0] cond,
                                     input logic [15:0] imm, output logic [31:0] w);
        bit f_rd = 0, f_rs1 = 0, f_rs2 = 0, f_cond = 0, f_imm = 0, ok = 0, alu;
        int opv = int'(op);
        longint v;
        alu = (op == 17 || op == 25 || op == 18 || op == 26 || op == 19 ||
               op == 27 || op == 20 || op == 28 || op == 21 || op == 29);
        if (c == 0) begin
            if (op <= 1) begin ok = 1; f_rd = 1; f_imm = 1; end
            else if (alu || (op >= 2 && op <= 5)) begin ok = 1; f_rd = 1; f_rs1 = 1; f_imm = 1; end
        end else if (c == 1) begin
            if (alu) begin ok = 1; f_rd = 1; f_rs1 = 1; f_rs2 = 1; end
            else if (op == 22) begin ok = 1; f_rd = 1; f_rs1 = 1; end
        end else if (c == 2) begin
            ok = 1; f_rd = 1; f_rs1 = 1; f_imm = 1; opv = int'(op[0]);
        end else if (op < 16) begin
            if (op == 0) begin ok = 1; f_imm = 1; end
            else if (op == 1) begin ok = 1; f_cond = 1; f_imm = 1; end
            else if (op == 2) begin ok = 1; f_rs1 = 1; f_imm = 1; end
            else if (op == 4 || op == 8) ok = 1;
        end
        v = longint'(c) * 64'h4000_0000 + longint'(opv) * 64'h0200_0000;
        if (f_rd)   v += longint'(rd)   * 64'h40_0000;
        if (f_cond) v += longint'(cond) * 64'h20_0000;
        if (f_rs1)  v += longint'(rs1)  * 64'h8_0000;
        if (f_rs2)  v += longint'(rs2)  * 64'h1_0000;
        if (f_imm)  v += longint'(imm);
        w = 32'(v);
        return ok;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            imem_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Write log plus hold check on stalled writes
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_data;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && imem_we) begin
                check("hold_addr", 32'(imem_addr), 32'(prev_addr));
                check("hold_data", imem_wdata, prev_data);
            end
            if (imem_we && imem_ready) begin
                log_addr.push_back(imem_addr);
                log_data.push_back(imem_wdata);
            end
            prev_stall <= imem_we && !imem_ready;
            prev_addr  <= imem_addr;
            prev_data  <= imem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [AW-1:0] b);
        log_addr.delete();
        log_data.delete();
        exp_data.delete();
        exp_base  = b;
        exp_err   = 0;
        start     = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] c, input logic [4:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input logic [3:0] cond,
                        input logic [15:0] imm, input bit fin);
        bit acc = 0;
        bit ok;
        logic [31:0] w;
        ok = model_enc(c, op, rd, rs1, rs2, cond, imm, w);
        in_class = c; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_cond = cond; in_imm = imm; in_valid = 1'b1; finish = fin;
        for (int k = 0; k < 60; k++) begin
            if (in_ready) begin
                @(posedge clk);
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        finish   = 1'b0;
        check("accept", 32'(acc), 32'd1);
        if (acc) begin
            if (ok) exp_data.push_back(w);
            else    exp_err = 1;
        end
    endtask

    task automatic finish_and_verify(input string tag, input bit pulse);
        int dcnt = 0;
        if (pulse) begin
            finish = 1'b1;
            @(negedge clk);
            finish = 1'b0;
        end
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                dcnt++;
                check({tag, "_done_after_writes"}, 32'(log_data.size()), 32'(exp_data.size()));
            end
            if (!busy) break;
            @(negedge clk);
        end
        check({tag, "_done_pulses"}, 32'(dcnt), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_nwrites"}, 32'(log_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < log_data.size(); i++) begin
            check({tag, "_addr"}, 32'(log_addr[i]), 32'(AW'(exp_base + AW'(i))));
            check({tag, "_data"}, log_data[i], exp_data[i]);
        end
        check({tag, "_words_written"}, 32'(words_written), 32'(exp_data.size()));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        logic [AW-1:0] rb;
        #1 rst = 1'b1;
        #2;
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_words", 32'(words_written), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // finish while idle is ignored
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        @(negedge clk);
        check("finish_in_idle", 32'(busy), 32'd0);

        // add r3,r1,#5 at base 0x010
        do_start(10'h010);
        check("busy_run", 32'(busy), 32'd1);
        check("in_ready_run", 32'(in_ready), 32'd1);
        send(2'b00, 5'b10001, 3'd3, 3'd1, 3'd7, 4'hF, 16'h0005, 0);
        check("add_we", 32'(imem_we), 32'd1);
        check("add_addr", 32'(imem_addr), 32'h010);
        check("add_word", imem_wdata, 32'h22C80005);
        finish_and_verify("add", 1);

        // branch then store; a mid-run start must not move the address
        do_start(10'h020);
        send(2'b11, 5'b00001, 3'd6, 3'd6, 3'd6, 4'b1010, 16'h0010, 0);
        start = 1'b1; base_addr = 10'h200;
        @(negedge clk);
        start = 1'b0;
        send(2'b10, 5'b00001, 3'd2, 3'd5, 3'd3, 4'h5, 16'h0004, 0);
        finish_and_verify("bstore", 1);
        check("bcond_word", log_data[0], 32'hC3400010);
        check("store_word", log_data[1], 32'h82A80004);
        check("store_addr", 32'(log_addr[1]), 32'h021);

        // NOP, HALT, then an illegal class-01 opcode
        do_start(10'h030);
        check("err_cleared", 32'(err), 32'd0);
        send(2'b11, 5'b00100, 3'd1, 3'd2, 3'd3, 4'h4, 16'hBEEF, 0);
        send(2'b11, 5'b01000, 3'd1, 3'd2, 3'd3, 4'h4, 16'hBEEF, 0);
        check("err_before_illegal", 32'(err), 32'd0);
        send(2'b01, 5'b00000, 3'd1, 3'd2, 3'd3, 4'h4, 16'hBEEF, 0);
        check("err_after_illegal", 32'(err), 32'd1);
        finish_and_verify("nophalt", 1);
        check("nop_word", log_data[0], 32'hC8000000);
        check("halt_word", log_data[1], 32'hD0000000);

        // memory stalled: FIFO fills and backpressures
        rdy_mode = 1;
        do_start(10'h100);
        for (int i = 0; i < 4; i++)
            send(2'b00, 5'b00001, 3'(i), 3'd0, 3'd0, 4'h0, 16'(16'h1000 + i), 0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_we", 32'(imem_we), 32'd1);
        check("full_addr", 32'(imem_addr), 32'h100);
        check("full_head", imem_wdata, exp_data[0]);
        @(negedge clk);
        @(negedge clk);
        check("stall_addr", 32'(imem_addr), 32'h100);
        check("stall_head", imem_wdata, exp_data[0]);
        rdy_mode = 0;
        send(2'b01, 5'b10110, 3'd4, 3'd5, 3'd6, 4'h0, 16'h0, 0);
        finish_and_verify("stall", 1);

        // address wrap, finish in the same cycle as the last accept
        do_start(10'h3FF);
        send(2'b00, 5'b00100, 3'd1, 3'd2, 3'd0, 4'h0, 16'hAAAA, 0);
        send(2'b01, 5'b11101, 3'd7, 3'd6, 3'd5, 4'h0, 16'hFFFF, 1);
        finish_and_verify("wrap", 0);
        check("wrap_addr1", 32'(log_addr[1]), 32'h000);

        // reset with words queued
        rdy_mode = 1;
        do_start(10'h055);
        for (int i = 0; i < 3; i++)
            send(2'b10, 5'b00000, 3'(i), 3'd1, 3'd0, 4'h0, 16'(i), 0);
        check("queued_we", 32'(imem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_we", 32'(imem_we), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        check("post_rst_we", 32'(imem_we), 32'd0);
        check("post_rst_words", 32'(words_written), 32'd0);
        do_start(10'h000);
        send(2'b00, 5'b00000, 3'd5, 3'd0, 3'd0, 4'h0, 16'h1234, 0);
        finish_and_verify("post_rst", 1);
        check("post_rst_first", log_data[0], 32'h01401234);

        // randomized bundles, varying memory readiness
        for (int r = 0; r < 3; r++) begin
            rdy_mode = (r == 1) ? 0 : 2;
            rb = AW'($urandom);
            do_start(rb);
            for (int i = 0; i < 40; i++) begin
                send(2'($urandom), 5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                     4'($urandom), 16'($urandom), 0);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            finish_and_verify("random", 1);
        end
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
